xfer_delay_sched: RTL and testbench

- Synthesizable sequencer for a two-stage delayed transfer datapath: a_in -> b_out -> c_out.
- A value change on a_in starts a transaction. The new value is held for D1 cycles, then loaded into b_out. b_out is held for D2 cycles, then copied into c_out.
- Input changes arriving while a transaction is in flight are dropped and counted.
- Sits between a free-running producer and downstream logic that needs fixed, sequenced update latencies.

---
 rtl/xfer_delay_sched.sv | 183 ++++++++++++++++++
 tb/tb_xfer_delay_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_delay_sched.sv
// Two-stage delayed transfer sequencer: a_in -> b_out after D1 cycles -> c_out after D2 more.
// Optional macro XFER_PEND_CAPTURE_EN adds a one-deep pending capture for changes seen while busy.
module xfer_delay_sched #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned D1     = 10,
    parameter int unsigned D2     = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a_in,
    input  logic              clr_drop,
    output logic [WIDTH-1:0]  b_out,
    output logic [WIDTH-1:0]  c_out,
    output logic              busy,
    output logic              entry_pulse,
    output logic              exit_pulse,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, S1, S2} state_t;

    localparam logic [CNT_W-1:0] C_D1M1 = CNT_W'(D1 - 1);
    localparam logic [CNT_W-1:0] C_D2M1 = CNT_W'(D2 - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_hold;
    logic [WIDTH-1:0]    r_a_prev;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_c;
    logic [DROP_W-1:0]   r_drop;
    logic                r_entry;
    logic                r_exit;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0]    w_hold_nxt;
    logic                w_change;
    logic                w_exit_edge;
    logic                w_load_b;
    logic                w_load_c;
    logic                w_entry_nxt;
    logic                w_exit_nxt;
    logic                w_drop_inc;

`ifdef XFER_PEND_CAPTURE_EN
    logic                r_pend_valid;
    logic [WIDTH-1:0]    r_pend_data;
    logic                w_pend_valid_nxt;
    logic [WIDTH-1:0]    w_pend_data_nxt;
`endif

    assign w_change    = (a_in != r_a_prev);
    assign w_exit_edge = (r_state == S2) && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_load_b    = 1'b0;
        w_load_c    = 1'b0;
        w_entry_nxt = 1'b0;
        w_exit_nxt  = 1'b0;
        w_drop_inc  = 1'b0;
`ifdef XFER_PEND_CAPTURE_EN
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_change) begin
                    w_hold_nxt  = a_in;
                    w_cnt_nxt   = C_D1M1;
                    w_state_nxt = S1;
                    w_entry_nxt = 1'b1;
                end
            end
            S1: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_load_b    = 1'b1;
                    w_cnt_nxt   = C_D2M1;
                    w_state_nxt = S2;
                end
            end
            S2: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_load_c    = 1'b1;
                    w_exit_nxt  = 1'b1;
                    w_state_nxt = IDLE;
`ifdef XFER_PEND_CAPTURE_EN
                    // A same-edge change beats the pending value; losing a valid pend is a drop.
                    if (w_change) begin
                        w_hold_nxt  = a_in;
                        w_cnt_nxt   = C_D1M1;
                        w_state_nxt = S1;
                        w_entry_nxt = 1'b1;
                        w_drop_inc  = r_pend_valid;
                    end else if (r_pend_valid) begin
                        w_hold_nxt  = r_pend_data;
                        w_cnt_nxt   = C_D1M1;
                        w_state_nxt = S1;
                        w_entry_nxt = 1'b1;
                    end
                    w_pend_valid_nxt = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if ((r_state != IDLE) && w_change) begin
`ifdef XFER_PEND_CAPTURE_EN
            if (!w_exit_edge) begin
                w_drop_inc       = r_pend_valid;
                w_pend_data_nxt  = a_in;
                w_pend_valid_nxt = 1'b1;
            end
`else
            w_drop_inc = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_a_prev <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_drop   <= '0;
            r_entry  <= 1'b0;
            r_exit   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hold   <= w_hold_nxt;
            r_a_prev <= a_in;
            r_entry  <= w_entry_nxt;
            r_exit   <= w_exit_nxt;
            if (w_load_b) begin
                r_b <= r_hold;
            end
            if (w_load_c) begin
                r_c <= r_b;
            end
            if (clr_drop) begin
                r_drop <= '0;
            end else if (w_drop_inc && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

`ifdef XFER_PEND_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
        end
    end
`endif

    assign b_out       = r_b;
    assign c_out       = r_c;
    assign busy        = (r_state != IDLE);
    assign entry_pulse = r_entry;
    assign exit_pulse  = r_exit;
    assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_xfer_delay_sched.sv
// Randomized scoreboard bench for xfer_delay_sched: three instances with different delays/widths
// checked against a transaction-window reference model.
module tb_xfer_delay_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] a_in;
    logic       clr_drop;

    always #5 clk = ~clk;

    logic [5:0] b0, c0, b1, c1, b2, c2;
    logic       busy0, en0, ex0, busy1, en1, ex1, busy2, en2, ex2;
    logic [7:0] drop0, drop2;
    logic [1:0] drop1;

    xfer_delay_sched #(.WIDTH(6), .D1(10), .D2(8), .CNT_W(8), .DROP_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .clr_drop(clr_drop), .b_out(b0), .c_out(c0),
        .busy(busy0), .entry_pulse(en0), .exit_pulse(ex0), .drop_cnt(drop0));
    xfer_delay_sched #(.WIDTH(6), .D1(3), .D2(2), .CNT_W(8), .DROP_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .clr_drop(clr_drop), .b_out(b1), .c_out(c1),
        .busy(busy1), .entry_pulse(en1), .exit_pulse(ex1), .drop_cnt(drop1));
    xfer_delay_sched #(.WIDTH(6), .D1(1), .D2(1), .CNT_W(8), .DROP_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .clr_drop(clr_drop), .b_out(b2), .c_out(c2),
        .busy(busy2), .entry_pulse(en2), .exit_pulse(ex2), .drop_cnt(drop2));

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic int d1_of(input int i);
        case (i)
            0:       return 10;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int d2_of(input int i);
        case (i)
            0:       return 8;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int dmax_of(input int i);
        return (i == 1) ? 3 : 255;
    endfunction

    // kind 0 = entry expected after edge cyc, kind 1 = exit with c_out == val after edge cyc
    typedef struct {
        int inst;
        int kind;
        int cyc;
        int val;
    } exp_t;
    exp_t q[$];

    int m_prev;
    int m_inflight[3], m_cap[3], m_end[3], m_val[3];
    int m_b[3], m_c[3], m_drop[3], m_pv[3], m_pd[3];

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%0d required=%0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input int kind, input int cyc, input int val);
        exp_t e;
        e.inst = i;
        e.kind = kind;
        e.cyc  = cyc;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_prev = 0;
        for (int i = 0; i < 3; i++) begin
            m_inflight[i] = 0; m_cap[i] = 0; m_end[i] = 0; m_val[i] = 0;
            m_b[i] = 0; m_c[i] = 0; m_drop[i] = 0; m_pv[i] = 0; m_pd[i] = 0;
        end
        q.delete();
    endtask

    // Effect of clock edge n given inputs a/clr, in terms of capture windows.
    task automatic model_step(input int n, input int a, input bit clr);
        bit chg;
        chg = (a != m_prev);
        for (int i = 0; i < 3; i++) begin
            int inc;
            bit newcap;
            int cv;
            inc = 0; newcap = 0; cv = 0;
            if (m_inflight[i] == 0) begin
                if (chg) begin newcap = 1; cv = a; end
            end else begin
                if (n == m_cap[i] + d1_of(i)) m_b[i] = m_val[i];
                if (n == m_end[i]) begin
                    m_c[i] = m_b[i];
                    m_inflight[i] = 0;
                    push_exp(i, 1, n, m_val[i]);
`ifdef XFER_PEND_CAPTURE_EN
                    if (chg) begin
                        newcap = 1; cv = a;
                        if (m_pv[i] != 0) inc = 1;
                    end else if (m_pv[i] != 0) begin
                        newcap = 1; cv = m_pd[i];
                    end
                    m_pv[i] = 0;
`else
                    if (chg) inc = 1;
`endif
                end else if (chg) begin
`ifdef XFER_PEND_CAPTURE_EN
                    if (m_pv[i] != 0) inc = 1;
                    m_pd[i] = a;
                    m_pv[i] = 1;
`else
                    inc = 1;
`endif
                end
            end
            if (clr) m_drop[i] = 0;
            else if (inc != 0 && m_drop[i] < dmax_of(i)) m_drop[i]++;
            if (newcap) begin
                m_inflight[i] = 1;
                m_cap[i] = n;
                m_val[i] = cv;
                m_end[i] = n + d1_of(i) + d2_of(i);
                push_exp(i, 0, n, cv);
            end
        end
        m_prev = a;
    endtask

    task automatic cyc_drive(input int a, input bit clr);
        @(negedge clk);
        a_in = 6'(a);
        clr_drop = clr;
        model_step(ecnt, a, clr);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_b"}, 0, int'(b0), 0);     chk({nm, "_c"}, 0, int'(c0), 0);
        chk({nm, "_busy"}, 0, int'(busy0), 0); chk({nm, "_en"}, 0, int'(en0), 0);
        chk({nm, "_ex"}, 0, int'(ex0), 0);   chk({nm, "_drop"}, 0, int'(drop0), 0);
        chk({nm, "_b"}, 1, int'(b1), 0);     chk({nm, "_busy"}, 1, int'(busy1), 0);
        chk({nm, "_drop"}, 1, int'(drop1), 0);
        chk({nm, "_c"}, 2, int'(c2), 0);     chk({nm, "_busy"}, 2, int'(busy2), 0);
    endtask

    task automatic do_reset(input int a_rel);
        @(negedge clk);
        rst_n = 1'b0;
        a_in = 6'(a_rel);
        clr_drop = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_step(ecnt, a_rel, 1'b0);
    endtask

    // Monitor: pops scoreboard records whenever a DUT presents a pulse.
    always @(posedge clk) begin
        int n;
        int sb[3], sc[3], sbusy[3], sen[3], sex[3], sdrop[3];
        #2;
        if (rst_n) begin
            n = ecnt - 1;
            sb[0] = int'(b0); sc[0] = int'(c0); sbusy[0] = int'(busy0);
            sen[0] = int'(en0); sex[0] = int'(ex0); sdrop[0] = int'(drop0);
            sb[1] = int'(b1); sc[1] = int'(c1); sbusy[1] = int'(busy1);
            sen[1] = int'(en1); sex[1] = int'(ex1); sdrop[1] = int'(drop1);
            sb[2] = int'(b2); sc[2] = int'(c2); sbusy[2] = int'(busy2);
            sen[2] = int'(en2); sex[2] = int'(ex2); sdrop[2] = int'(drop2);
            for (int i = 0; i < 3; i++) begin
                chk("busy", i, sbusy[i], m_inflight[i]);
                chk("b_out", i, sb[i], m_b[i]);
                chk("c_out", i, sc[i], m_c[i]);
                chk("drop_cnt", i, sdrop[i], m_drop[i]);
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0 && sen[i] != 0) || (k == 1 && sex[i] != 0)) begin
                        int idx;
                        idx = -1;
                        for (int j = 0; j < q.size(); j++) begin
                            if (idx < 0 && q[j].inst == i && q[j].kind == k) idx = j;
                        end
                        if (idx < 0) begin
                            chk(k == 0 ? "entry_unexpected" : "exit_unexpected", i, 1, 0);
                        end else begin
                            chk(k == 0 ? "entry_cycle" : "exit_cycle", i, n, q[idx].cyc);
                            if (k == 1) chk("exit_c_val", i, sc[i], q[idx].val);
                            q.delete(idx);
                        end
                    end
                end
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (q[j].inst == i && q[j].cyc < n) begin
                        chk(q[j].kind == 0 ? "entry_missing" : "exit_missing", i, n, q[j].cyc);
                        q.delete(j);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in = '0;
        clr_drop = 1'b0;
        model_reset();
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_step(ecnt, 0, 1'b0);

        // 0x05 transaction with two in-flight changes that must be dropped
        cyc_drive(6'h05, 1'b0);
        repeat (2) cyc_drive(6'h05, 1'b0);
        repeat (4) cyc_drive(6'h11, 1'b0);
        repeat (25) cyc_drive(6'h22, 1'b0);

        for (int k = 0; k < 700; k++) begin
            cyc_drive(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : m_prev,
                      ($urandom_range(0, 39) == 0));
        end

        // Reset mid-transaction, then release with a nonzero input
        repeat (20) cyc_drive(m_prev, 1'b0);
        cyc_drive(6'h07, 1'b0);
        repeat (11) cyc_drive(6'h07, 1'b0);
        do_reset(6'h22);
        repeat (25) cyc_drive(6'h22, 1'b0);

        // Dense changes to drive saturation, with clears landing on drop cycles
        for (int k = 0; k < 300; k++) begin
            cyc_drive(int'($urandom_range(0, 63)), ($urandom_range(0, 24) == 0));
        end
        for (int k = 0; k < 1200; k++) begin
            cyc_drive(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : m_prev,
                      ($urandom_range(0, 59) == 0));
        end
        repeat (60) cyc_drive(m_prev, 1'b0);
        @(negedge clk);
        chk("queue_drained", 0, q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
